// File: rtl/pwr_cntr_bank_pkg.sv
// Shared defaults and elaboration helpers for the transition-counter bank.
package pwr_cntr_bank_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SIG_W  = 8;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_ADDR_W = 2;

  // Smallest n with 2**n >= value; usable in constant expressions.
  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwr_cntr_bank_toggle_popcount.sv
// Number of bits that differ between the current and previous sample of a bus.
module toggle_popcount
  import pwr_cntr_bank_pkg::*;
#(
  parameter int SIG_W = DEF_SIG_W,
  parameter int INC_W = clog2_f(SIG_W + 1)
) (
  input  logic [SIG_W-1:0] cur,
  input  logic [SIG_W-1:0] prev,
  output logic [INC_W-1:0] inc
);

  logic [SIG_W-1:0] diff_s;
  logic [INC_W-1:0] sum_s;

  assign diff_s = cur ^ prev;

  // Sum the toggled bits.
  always_comb begin
    sum_s = {INC_W{1'b0}};
    for (int i = 0; i < SIG_W; i++) begin
      sum_s = sum_s + INC_W'(diff_s[i]);
    end
  end

  assign inc = sum_s;

endmodule

// File: rtl/pwr_cntr_bank.sv
// Bank of saturating per-channel toggle counters with a registered read port.
module pwr_cntr_bank
  import pwr_cntr_bank_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SIG_W     = DEF_SIG_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit CLR_ON_RD = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    cnt_en,
  input  logic [NUM_CH*SIG_W-1:0] sig_in,
  input  logic                    clr_all,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_ovf,
  output logic                    ovf_any
);

  localparam int INC_W    = clog2_f(SIG_W + 1);
  localparam int NUM_SLOT = 32'sd1 <<< ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (NUM_SLOT < NUM_CH) begin : g_addr_chk
    $fatal(1, "pwr_cntr_bank: ADDR_W too small for NUM_CH");
  end

  logic              primed_r;
  logic              ovf_any_r;
  logic              rd_valid_r;
  logic [CNT_W-1:0]  rd_data_r;
  logic              rd_ovf_r;
  logic [CNT_W-1:0]  cnt_s [NUM_CH];
  logic [NUM_CH-1:0] ovf_s;
  logic [NUM_CH-1:0] ovf_nxt_s;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [SIG_W-1:0] cur_s;
    logic [SIG_W-1:0] prev_r;
    logic [INC_W-1:0] inc_s;
    logic [CNT_W:0]   sum_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_ch_s;
    logic             rd_hit_s;

    assign cur_s    = sig_in[k*SIG_W +: SIG_W];
    assign rd_hit_s = CLR_ON_RD && rd_req && (rd_addr == ADDR_W'(k));

    toggle_popcount #(.SIG_W(SIG_W), .INC_W(INC_W)) u_pop (
      .cur  (cur_s),
      .prev (prev_r),
      .inc  (inc_s)
    );

    // Next count: a clearing read restarts from zero but still keeps this edge's toggles.
    always_comb begin
      sum_s = {1'b0, (rd_hit_s ? {CNT_W{1'b0}} : cnt_r)} + (CNT_W+1)'(inc_s);
      if (clr_all) begin
        cnt_nxt_s    = {CNT_W{1'b0}};
        ovf_nxt_ch_s = 1'b0;
      end else if (cnt_en && primed_r) begin
        if (sum_s[CNT_W]) begin
          cnt_nxt_s    = CNT_MAX;
          ovf_nxt_ch_s = 1'b1;
        end else begin
          cnt_nxt_s    = sum_s[CNT_W-1:0];
          ovf_nxt_ch_s = ovf_r && !rd_hit_s;
        end
      end else if (rd_hit_s) begin
        cnt_nxt_s    = {CNT_W{1'b0}};
        ovf_nxt_ch_s = 1'b0;
      end else begin
        cnt_nxt_s    = cnt_r;
        ovf_nxt_ch_s = ovf_r;
      end
    end

    // Channel state; prev tracks the bus even outside the counting window.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        prev_r <= {SIG_W{1'b0}};
        cnt_r  <= {CNT_W{1'b0}};
        ovf_r  <= 1'b0;
      end else begin
        prev_r <= cur_s;
        cnt_r  <= cnt_nxt_s;
        ovf_r  <= ovf_nxt_ch_s;
      end
    end

    assign cnt_s[k]     = cnt_r;
    assign ovf_s[k]     = ovf_r;
    assign ovf_nxt_s[k] = ovf_nxt_ch_s;
  end

  // Unpopulated addresses read as zero without any range compare.
  logic [CNT_W-1:0]    slot_cnt_s [NUM_SLOT];
  logic [NUM_SLOT-1:0] slot_ovf_s;

  for (genvar s = 0; s < NUM_SLOT; s++) begin : g_slot
    if (s < NUM_CH) begin : g_used
      assign slot_cnt_s[s] = cnt_s[s];
      assign slot_ovf_s[s] = ovf_s[s];
    end else begin : g_unused
      assign slot_cnt_s[s] = {CNT_W{1'b0}};
      assign slot_ovf_s[s] = 1'b0;
    end
  end

  // Priming flag and summary overflow flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      primed_r  <= 1'b0;
      ovf_any_r <= 1'b0;
    end else begin
      primed_r  <= 1'b1;
      ovf_any_r <= |ovf_nxt_s;
    end
  end

  // Registered read mux; data holds between requests.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {CNT_W{1'b0}};
      rd_ovf_r   <= 1'b0;
    end else if (rd_req) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= slot_cnt_s[rd_addr];
      rd_ovf_r   <= slot_ovf_s[rd_addr];
    end else begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= rd_data_r;
      rd_ovf_r   <= rd_ovf_r;
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign rd_ovf   = rd_ovf_r;
  assign ovf_any  = ovf_any_r;

endmodule
